// File: rtl/fpmult_stream_ctrl.sv
// ---------------------------------------------------------------------------
// fpmult_stream_ctrl
//
// Streaming wrapper placed directly around an fpmult core. It accepts operand
// triples on a valid/ready stream, issues them to fpmult with a one-cycle
// start pulse, and captures each product and its out-of-range flags when
// fpmult raises valid. Captured results go through a small first-word-fall-
// through FIFO onto a valid/ready result stream. The block also keeps a
// saturating count of completed operations, sticky OOR flags, and a sticky
// watchdog error for operations that never complete.
//
// Ports
//   clk_in           clock, rising edge
//   rst_in_N         asynchronous active-low reset (also resets fpmult)
//   s_valid_in / s_ready_out / s_x_in / s_y_in / s_round_in
//                    operand stream
//   fpm_x_out / fpm_y_out / fpm_round_out / fpm_start_out
//                    operands and start strobe towards fpmult
//   fpm_p_in / fpm_oor_in / fpm_valid_in / fpm_ready_in
//                    product, flags (bit0 SUB, bit1 NAN, bit2 INF, bit3 ZERO)
//                    and handshake from fpmult
//   m_valid_out / m_ready_in / m_p_out / m_oor_out
//                    result stream (FIFO head, zero when empty)
//   clr_in           synchronous clear of done count and sticky flags
//   done_cnt_out     completed operations, saturating
//   oor_sticky_out   OR of every captured oor since reset/clear
//   err_timeout_out  sticky watchdog error, cleared only by reset
// ---------------------------------------------------------------------------
module fpmult_stream_ctrl #(
    parameter int P          = 8,
    parameter int Q          = 8,
    parameter int FIFO_DEPTH = 2,
    parameter int TIMEOUT    = 64,
    parameter int CNT_W      = 16,
    localparam int W         = P + Q
) (
    input  logic             clk_in,
    input  logic             rst_in_N,
    input  logic             s_valid_in,
    output logic             s_ready_out,
    input  logic [W-1:0]     s_x_in,
    input  logic [W-1:0]     s_y_in,
    input  logic [1:0]       s_round_in,
    output logic [W-1:0]     fpm_x_out,
    output logic [W-1:0]     fpm_y_out,
    output logic [1:0]       fpm_round_out,
    output logic             fpm_start_out,
    input  logic [W-1:0]     fpm_p_in,
    input  logic [3:0]       fpm_oor_in,
    input  logic             fpm_valid_in,
    input  logic             fpm_ready_in,
    output logic             m_valid_out,
    input  logic             m_ready_in,
    output logic [W-1:0]     m_p_out,
    output logic [3:0]       m_oor_out,
    input  logic             clr_in,
    output logic [CNT_W-1:0] done_cnt_out,
    output logic [3:0]       oor_sticky_out,
    output logic             err_timeout_out
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

    state_t             state_reg, state_next;
    logic [W-1:0]       x_reg, y_reg;
    logic [1:0]         round_reg;
    logic               prev_valid_reg;
    logic [TW-1:0]      wdog_reg;
    logic               err_reg;
    logic [CNT_W-1:0]   done_cnt_reg, done_cnt_next;
    logic [3:0]         sticky_reg, sticky_next;
    logic [AW-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]      count_reg;

    logic               fifo_full;
    logic               accept;
    logic               capture;
    logic               timeout;
    logic               push, pop;

    logic [FIFO_DEPTH-1:0][W-1:0] entry_p_flat;
    logic [FIFO_DEPTH-1:0][3:0]   entry_oor_flat;

    assign fifo_full = (count_reg == CW'(FIFO_DEPTH));
    assign accept    = s_valid_in && s_ready_out;
    // Only a fresh rising edge of valid counts; a level held over from the
    // previous operation must not be mistaken for this one's completion.
    assign capture   = (state_reg == ST_WAIT) && fpm_valid_in && !prev_valid_reg;
    assign timeout   = (state_reg == ST_WAIT) && !capture &&
                       (wdog_reg == TW'(TIMEOUT - 1));
    assign push      = capture;
    assign pop       = m_valid_out && m_ready_in;

    // ---------------- FSM next state / outputs ----------------
    always_comb begin
        state_next    = state_reg;
        s_ready_out   = 1'b0;
        fpm_start_out = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // At most one op is in flight, so a free slot here guarantees
                // room for its result when it completes.
                s_ready_out = fpm_ready_in && !fifo_full;
                if (s_valid_in && fpm_ready_in && !fifo_full)
                    state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                fpm_start_out = 1'b1;
                state_next    = ST_WAIT;
            end
            ST_WAIT: begin
                if (capture || timeout)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Statistics: clear is applied first so a coincident capture still counts.
    always_comb begin
        done_cnt_next = clr_in ? '0 : done_cnt_reg;
        sticky_next   = clr_in ? 4'b0 : sticky_reg;
        if (capture) begin
            if (done_cnt_next != {CNT_W{1'b1}})
                done_cnt_next = done_cnt_next + CNT_W'(1);
            sticky_next = sticky_next | fpm_oor_in;
        end
    end

    // ---------------- control and datapath registers ----------------
    always_ff @(posedge clk_in or negedge rst_in_N) begin
        if (!rst_in_N) begin
            state_reg      <= ST_IDLE;
            x_reg          <= '0;
            y_reg          <= '0;
            round_reg      <= 2'b0;
            prev_valid_reg <= 1'b0;
            wdog_reg       <= '0;
            err_reg        <= 1'b0;
            done_cnt_reg   <= '0;
            sticky_reg     <= 4'b0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            done_cnt_reg <= done_cnt_next;
            sticky_reg   <= sticky_next;

            if (accept) begin
                x_reg     <= s_x_in;
                y_reg     <= s_y_in;
                round_reg <= s_round_in;
            end

            if (state_reg == ST_ISSUE)
                wdog_reg <= '0;
            else if (state_reg == ST_WAIT)
                wdog_reg <= wdog_reg + TW'(1);

            if (state_reg == ST_ISSUE || state_reg == ST_WAIT)
                prev_valid_reg <= fpm_valid_in;

            if (timeout)
                err_reg <= 1'b1;

            if (push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    // ---------------- FIFO storage, one register pair per entry ----------------
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : gen_entry
            logic [W-1:0] p_reg;
            logic [3:0]   oor_reg;
            always_ff @(posedge clk_in or negedge rst_in_N) begin
                if (!rst_in_N) begin
                    p_reg   <= '0;
                    oor_reg <= 4'b0;
                end else if (push && (wr_ptr_reg == AW'(gi))) begin
                    p_reg   <= fpm_p_in;
                    oor_reg <= fpm_oor_in;
                end
            end
            assign entry_p_flat[gi]   = p_reg;
            assign entry_oor_flat[gi] = oor_reg;
        end
    endgenerate

    // ---------------- outputs ----------------
    assign fpm_x_out       = x_reg;
    assign fpm_y_out       = y_reg;
    assign fpm_round_out   = round_reg;
    assign m_valid_out     = (count_reg != '0);
    assign m_p_out         = m_valid_out ? entry_p_flat[rd_ptr_reg] : '0;
    assign m_oor_out       = m_valid_out ? entry_oor_flat[rd_ptr_reg] : 4'b0;
    assign done_cnt_out    = done_cnt_reg;
    assign oor_sticky_out  = sticky_reg;
    assign err_timeout_out = err_reg;

endmodule

// File: tb/tb_fpmult_stream_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for fpmult_stream_ctrl. A behavioural fpmult stand-in answers a
// small table of bf16-style products with a random latency, or hangs on
// request. Expected results are queued when an operand is issued and checked
// in order as beats leave the result stream.
// ---------------------------------------------------------------------------
module tb_fpmult_stream_ctrl;

    localparam int W = 16;

    logic          clk_in = 1'b0;
    logic          rst_in_N;
    logic          s_valid_in;
    logic          s_ready_out;
    logic [W-1:0]  s_x_in, s_y_in;
    logic [1:0]    s_round_in;
    logic [W-1:0]  fpm_x_out, fpm_y_out;
    logic [1:0]    fpm_round_out;
    logic          fpm_start_out;
    logic [W-1:0]  fpm_p_in;
    logic [3:0]    fpm_oor_in;
    logic          fpm_valid_in;
    logic          fpm_ready_in;
    logic          m_valid_out;
    logic          m_ready_in;
    logic [W-1:0]  m_p_out;
    logic [3:0]    m_oor_out;
    logic          clr_in;
    logic [15:0]   done_cnt_out;
    logic [3:0]    oor_sticky_out;
    logic          err_timeout_out;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;
    int start_cnt = 0;

    logic [19:0] sb_q[$];

    fpmult_stream_ctrl dut (
        .clk_in          (clk_in),
        .rst_in_N        (rst_in_N),
        .s_valid_in      (s_valid_in),
        .s_ready_out     (s_ready_out),
        .s_x_in          (s_x_in),
        .s_y_in          (s_y_in),
        .s_round_in      (s_round_in),
        .fpm_x_out       (fpm_x_out),
        .fpm_y_out       (fpm_y_out),
        .fpm_round_out   (fpm_round_out),
        .fpm_start_out   (fpm_start_out),
        .fpm_p_in        (fpm_p_in),
        .fpm_oor_in      (fpm_oor_in),
        .fpm_valid_in    (fpm_valid_in),
        .fpm_ready_in    (fpm_ready_in),
        .m_valid_out     (m_valid_out),
        .m_ready_in      (m_ready_in),
        .m_p_out         (m_p_out),
        .m_oor_out       (m_oor_out),
        .clr_in          (clr_in),
        .done_cnt_out    (done_cnt_out),
        .oor_sticky_out  (oor_sticky_out),
        .err_timeout_out (err_timeout_out)
    );

    always #5 clk_in = ~clk_in;

    // ---------------- fpmult stand-in ----------------
    bit          stub_hang = 1'b0;
    logic        stub_busy;
    int          stub_lat;
    logic [W-1:0] stub_pend_p;
    logic [3:0]   stub_pend_oor;

    function automatic logic [19:0] stub_lookup(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [31:0] key;
        key = {x, y};
        case (key)
            32'h3F80_4000: return {16'h4000, 4'b0000};
            32'h7FC0_3F80: return {16'h7FC0, 4'b0010};
            32'h3F80_0000: return {16'h0000, 4'b1000};
            32'h4000_4000: return {16'h4080, 4'b0000};
            32'h3F80_3F80: return {16'h3F80, 4'b0000};
            32'h7F80_4000: return {16'h7F80, 4'b0100};
            default:       return {16'hBAD0, 4'b0000};
        endcase
    endfunction

    assign fpm_ready_in = !stub_busy;

    always @(posedge clk_in or negedge rst_in_N) begin
        if (!rst_in_N) begin
            fpm_valid_in  <= 1'b0;
            fpm_p_in      <= '0;
            fpm_oor_in    <= 4'b0;
            stub_busy     <= 1'b0;
            stub_lat      <= 0;
            stub_pend_p   <= '0;
            stub_pend_oor <= 4'b0;
        end else if (fpm_start_out) begin
            fpm_valid_in                 <= 1'b0;
            stub_busy                    <= !stub_hang;
            stub_lat                     <= int'($urandom_range(1, 4));
            {stub_pend_p, stub_pend_oor} <= stub_lookup(fpm_x_out, fpm_y_out);
        end else if (stub_busy) begin
            if (stub_lat == 0) begin
                fpm_valid_in <= 1'b1;
                fpm_p_in     <= stub_pend_p;
                fpm_oor_in   <= stub_pend_oor;
                stub_busy    <= 1'b0;
            end else begin
                stub_lat <= stub_lat - 1;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
            $display("check %s: observed %h expected %h", tag, obs, exp);
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bound_fail(input string tag);
        total_cnt++;
        fail_cnt++;
        $error("FAIL %s: wait bound expired", tag);
    endtask

    always @(negedge clk_in) begin
        if (fpm_start_out)
            start_cnt++;
    end

    // Scoreboard: every beat taken on the result stream is compared in order.
    always @(negedge clk_in) begin
        logic [19:0] e;
        if (rst_in_N && m_valid_out && m_ready_in) begin
            if (sb_q.size() == 0) begin
                bound_fail("unexpected_beat");
            end else begin
                e = sb_q.pop_front();
                check("beat_p", 32'(m_p_out), 32'(e[19:4]));
                check("beat_oor", 32'(m_oor_out), 32'(e[3:0]));
            end
        end
    end

    task automatic send_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] rnd,
                           input bit push, input logic [W-1:0] ep, input logic [3:0] eo);
        int n;
        n = 0;
        @(negedge clk_in);
        s_valid_in = 1'b1;
        s_x_in     = x;
        s_y_in     = y;
        s_round_in = rnd;
        while (!s_ready_out && n < 500) begin
            @(negedge clk_in);
            n++;
        end
        if (!s_ready_out) begin
            bound_fail("send_accept");
            s_valid_in = 1'b0;
            return;
        end
        if (push)
            sb_q.push_back({ep, eo});
        @(posedge clk_in);
        #1 s_valid_in = 1'b0;
        $display("op issued x=%h y=%h round=%0d", x, y, rnd);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || m_valid_out || dut.state_reg != 0) && n < 500) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 500)
            bound_fail("drain");
        @(negedge clk_in);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        rst_in_N   = 1'b0;
        s_valid_in = 1'b0;
        s_x_in     = '0;
        s_y_in     = '0;
        s_round_in = 2'b0;
        m_ready_in = 1'b0;
        clr_in     = 1'b0;
        repeat (3) @(negedge clk_in);

        // Reset state
        check("rst_done_cnt", 32'(done_cnt_out), 0);
        check("rst_sticky", 32'(oor_sticky_out), 0);
        check("rst_err", 32'(err_timeout_out), 0);
        check("rst_m_valid", 32'(m_valid_out), 0);
        check("rst_m_p", 32'(m_p_out), 0);
        check("rst_start", 32'(fpm_start_out), 0);
        check("rst_fpm_x", 32'(fpm_x_out), 0);
        rst_in_N = 1'b1;
        @(posedge clk_in);
        #1 m_ready_in = 1'b1;

        // Basic product
        send_op(16'h3F80, 16'h4000, 2'd0, 1'b1, 16'h4000, 4'b0000);
        wait_drain();
        check("basic_done_cnt", 32'(done_cnt_out), 1);
        check("basic_start_cycles", 32'(start_cnt), 1);

        // NaN passthrough and zero
        send_op(16'h7FC0, 16'h3F80, 2'd1, 1'b1, 16'h7FC0, 4'b0010);
        send_op(16'h3F80, 16'h0000, 2'd2, 1'b1, 16'h0000, 4'b1000);
        wait_drain();
        check("nan_zero_sticky", 32'(oor_sticky_out), 32'b1010);
        check("nan_zero_done_cnt", 32'(done_cnt_out), 3);

        // Backpressure: FIFO fills with two results, third op is held off
        @(posedge clk_in);
        #1 m_ready_in = 1'b0;
        send_op(16'h3F80, 16'h4000, 2'd0, 1'b1, 16'h4000, 4'b0000);
        send_op(16'h4000, 16'h4000, 2'd0, 1'b1, 16'h4080, 4'b0000);
        @(negedge clk_in);
        s_valid_in = 1'b1;
        s_x_in     = 16'h3F80;
        s_y_in     = 16'h3F80;
        s_round_in = 2'd3;
        repeat (20) @(negedge clk_in);
        check("bp_s_ready_held", 32'(s_ready_out), 0);
        check("bp_m_valid", 32'(m_valid_out), 1);
        check("bp_done_cnt", 32'(done_cnt_out), 5);
        sb_q.push_back({16'h3F80, 4'b0000});
        @(posedge clk_in);
        #1 m_ready_in = 1'b1;
        @(posedge clk_in);
        #1 m_ready_in = 1'b0;
        @(negedge clk_in);
        check("bp_third_ready", 32'(s_ready_out), 1);
        @(posedge clk_in);
        #1 s_valid_in = 1'b0;
        $display("op issued x=3f80 y=3f80 round=3");
        m_ready_in = 1'b1;
        wait_drain();
        check("bp_done_cnt_final", 32'(done_cnt_out), 6);

        // Watchdog: fpmult never answers
        stub_hang = 1'b1;
        send_op(16'h3F80, 16'h3F80, 2'd0, 1'b0, 16'h0, 4'b0);
        @(negedge clk_in);
        check("wd_start_pulse", 32'(fpm_start_out), 1);
        @(posedge clk_in);
        repeat (63) @(posedge clk_in);
        #1 check("wd_err_before", 32'(err_timeout_out), 0);
        @(posedge clk_in);
        #1;
        check("wd_err_after", 32'(err_timeout_out), 1);
        check("wd_no_beat", 32'(m_valid_out), 0);
        check("wd_s_ready", 32'(s_ready_out), 1);
        check("wd_done_cnt", 32'(done_cnt_out), 6);
        stub_hang = 1'b0;

        // Clear coincident with capture of an INF result
        send_op(16'h7FC0, 16'h3F80, 2'd0, 1'b1, 16'h7FC0, 4'b0010);
        wait_drain();
        send_op(16'h7F80, 16'h4000, 2'd0, 1'b1, 16'h7F80, 4'b0100);
        n = 0;
        while (fpm_valid_in && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        while (!fpm_valid_in && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 50) begin
            bound_fail("clr_wait_valid");
        end else begin
            clr_in = 1'b1;
            @(posedge clk_in);
            #1 clr_in = 1'b0;
            check("clr_done_cnt", 32'(done_cnt_out), 1);
            check("clr_sticky", 32'(oor_sticky_out), 32'b0100);
            check("clr_err_kept", 32'(err_timeout_out), 1);
        end
        wait_drain();

        // Asynchronous reset while waiting on fpmult
        stub_hang = 1'b1;
        send_op(16'h3F80, 16'h3F80, 2'd0, 1'b0, 16'h0, 4'b0);
        repeat (5) @(posedge clk_in);
        #2 rst_in_N = 1'b0;
        #1;
        check("arst_done_cnt", 32'(done_cnt_out), 0);
        check("arst_sticky", 32'(oor_sticky_out), 0);
        check("arst_err", 32'(err_timeout_out), 0);
        check("arst_fpm_x", 32'(fpm_x_out), 0);
        check("arst_start", 32'(fpm_start_out), 0);
        check("arst_m_valid", 32'(m_valid_out), 0);
        @(negedge clk_in);
        rst_in_N  = 1'b1;
        stub_hang = 1'b0;
        send_op(16'h3F80, 16'h3F80, 2'd0, 1'b1, 16'h3F80, 4'b0000);
        wait_drain();
        check("arst_after_done_cnt", 32'(done_cnt_out), 1);

        check("sb_empty", 32'(sb_q.size()), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fpmult_stream_ctrl.md
Name: fpmult_stream_ctrl

Overview:
- Streaming front/back-end for fpmult, instantiated directly around it.
- Accepts operand triples (x, y, round) on a valid/ready stream and issues each to fpmult with the start/ready protocol.
- Captures p/oor on completion and queues the results in a small FIFO for a valid/ready result stream.
- Maintains a completed-operation counter, sticky OOR flags and a watchdog error.

Parameters:
- P, 8: fraction field width incl. hidden position (mantissa bits = P-1); must match fpmult.
- Q, 8: exponent width; word width W = P+Q.
- FIFO_DEPTH, 2: result FIFO entries; power of two, >= 2.
- TIMEOUT, 64: max cycles in WAIT before abort.
- CNT_W, 16: completed-operation counter width.

Ports:
- clk_in  in  1  clock, all logic on rising edge.
- rst_in_N  in  1  asynchronous active-low reset; also drives fpmult's reset.
- s_valid_in  in  1  operand valid.
- s_ready_out  out  1  operand accepted when high with s_valid_in.
- s_x_in  in  W  operand X, sign at MSB.
- s_y_in  in  W  operand Y.
- s_round_in  in  2  rounding mode.
- fpm_x_out  out  W  to fpmult x_in.
- fpm_y_out  out  W  to fpmult y_in.
- fpm_round_out  out  2  to fpmult round_in.
- fpm_start_out  out  1  to fpmult start_in.
- fpm_p_in  in  W  from fpmult p_out.
- fpm_oor_in  in  4  from fpmult oor_out; bit0 SUB, bit1 NAN, bit2 INF, bit3 ZERO.
- fpm_valid_in  in  1  from fpmult valid_out.
- fpm_ready_in  in  1  from fpmult ready_out.
- m_valid_out  out  1  result available (FIFO non-empty).
- m_ready_in  in  1  downstream accepts result.
- m_p_out  out  W  FIFO head product.
- m_oor_out  out  4  FIFO head oor.
- clr_in  in  1  synchronous clear of statistics.
- done_cnt_out  out  CNT_W  completed operations, saturating.
- oor_sticky_out  out  4  OR of all captured oor since reset/clear.
- err_timeout_out  out  1  sticky watchdog error.

Behaviour:
- Reset (async, any state): FSM=IDLE; FIFO empty; operand regs, fpm_* outputs, m_p_out, m_oor_out, counters, sticky and error all 0. fpm_start_out=0.
- fpmult protocol: operands must be stable on the cycle fpm_start_out=1. fpmult lowers valid_out after sampling start and raises it when done, holding it until the next start.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - s_ready_out = fpm_ready_in && (fifo_count < FIFO_DEPTH); combinational, 0 in all other states.
  - On handshake: register x/y/round onto fpm_*_out; go to ISSUE.
- ISSUE:
  - fpm_start_out=1 for exactly this one cycle; operands held.
  - Clear the watchdog and capture fpm_valid_in into prev_valid; go to WAIT.
- WAIT:
  - Operands held (not X'd).
  - Capture on a rising edge of fpm_valid_in (current=1, prev_valid=0). A level high left over from the previous op is never captured.
  - On capture:
    - push {fpm_p_in, fpm_oor_in} into the FIFO;
    - done_cnt += 1, saturating at all-ones;
    - oor_sticky |= fpm_oor_in;
    - go to IDLE.
  - Watchdog counts WAIT cycles. On reaching TIMEOUT without capture: set err_timeout_out (cleared only by reset), push nothing, go to IDLE.
- Capture-to-accept latency: result is visible on m_* the cycle after capture. Earliest next accept is the cycle after capture.
- FIFO:
  - First-word-fall-through.
  - Pop when m_valid_out && m_ready_in.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Push is never attempted when full; the issue gate guarantees a free slot, since at most one op is in flight.
  - m_p_out/m_oor_out = 0 when empty.
  - Pointers wrap modulo FIFO_DEPTH.
- clr_in: zeroes done_cnt and oor_sticky next edge. If it coincides with a capture, the result is done_cnt=1 and sticky=fpm_oor_in (clear then capture). err_timeout_out is not affected.
- NaN results pass through unmodified.

Test Plan:
- Basic: x=3F80, y=4000, round=0 -> one m beat p=4000, oor=0000. done_cnt=1; fpm_start_out high exactly one cycle.
- NaN/zero: 7FC0*3F80 then 3F80*0000 -> m beats oor=0010 (p exponent all-ones, nonzero mantissa) then p=0000, oor=1000. oor_sticky=1010.
- Backpressure, FIFO_DEPTH=2, m_ready_in=0:
  - send 3 ops -> first two complete; s_ready_out stays 0 for the third.
  - raise m_ready_in for one beat -> third accepted; results pop in order.
- Watchdog: stub fpmult never raising valid, TIMEOUT=64 -> ISSUE, then after 64 WAIT cycles err_timeout_out=1. No m beat; s_ready_out=1 next cycle.
- Reset mid-WAIT: assert rst_in_N=0 asynchronously between clocks -> all outputs 0 immediately. After release, 3F80*3F80 -> p=3F80.
- clr_in coincident with capture of 7F80*4000 (INF) -> done_cnt=1, oor_sticky=0100 on the following cycle.
